instruction_fetch: RTL

Instruction fetch stage sitting directly upstream of the unified `memory` block. It owns the program counter, drives the memory read port (address, memRead, memWrite, writeData) and captures the registered read data one cycle later. It presents each fetched word, with its PC, to decode over a valid/ready handshake, and accepts branch redirects from execute.

---
 rtl/instruction_fetch.sv | 80 ++++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, issues one memory read per instruction,
// captures the registered read data and hands it to decode over valid/ready.
module instruction_fetch #(
  parameter int adressBusWidth   = 16,
  parameter int instructionWidth = 32,
  parameter logic [adressBusWidth-1:0] resetVector = 'h400
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        fetchEnable,
  input  logic                        branchTaken,
  input  logic [adressBusWidth-1:0]   branchTarget,
  input  logic                        instrReady,
  input  logic [instructionWidth-1:0] memDataIn,
  output logic [adressBusWidth-1:0]   memAddress,
  output logic                        memRead,
  output logic                        memWrite,
  output logic [instructionWidth-1:0] memWriteData,
  output logic [instructionWidth-1:0] instr,
  output logic [adressBusWidth-1:0]   instrPc,
  output logic                        instrValid
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

  localparam logic [adressBusWidth-1:0] PC_STEP = {{(adressBusWidth-1){1'b0}}, 1'b1};

  state_t                      r_state;
  state_t                      w_next;
  logic [adressBusWidth-1:0]   r_pc;
  logic [instructionWidth-1:0] r_instr;
  logic [adressBusWidth-1:0]   r_instrPc;

  always_ff @(posedge clk) begin
    if (clear) r_state <= ST_FETCH;
    else       r_state <= w_next;
  end

  // A redirect abandons whatever is in flight or held and restarts fetching.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_FETCH: if (fetchEnable) w_next = ST_WAIT;
      ST_WAIT:  w_next = ST_HOLD;
      ST_HOLD:  if (instrReady) w_next = ST_FETCH;
      default:  w_next = ST_FETCH;
    endcase
    if (branchTaken) w_next = ST_FETCH;
  end

  always_comb begin
    memRead    = (r_state == ST_FETCH) && fetchEnable && !clear;
    instrValid = (r_state == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      r_pc      <= resetVector;
      r_instr   <= '0;
      r_instrPc <= '0;
    end else if (branchTaken) begin
      r_pc <= branchTarget;
    end else if (r_state == ST_WAIT) begin
      r_instr   <= memDataIn;
      r_instrPc <= r_pc;
      r_pc      <= r_pc + PC_STEP;
    end
  end

  assign memAddress   = r_pc;
  assign memWrite     = 1'b0;
  assign memWriteData = '0;
  assign instr        = r_instr;
  assign instrPc      = r_instrPc;

endmodule
